// File: rtl/ahb_mtx_decoder_gen_pkg.sv
// ---------------------------------------------------------------------------
// ahb_mtx_gen_pkg
// Shared constants for the generic AHB matrix input-stage decoder:
//   - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//   - HRESP encodings (OKAY/ERROR)
//   - default-slave FSM state encoding
//   - width of the decoded address field (HADDR[31:10])
// ---------------------------------------------------------------------------
package ahb_mtx_gen_pkg;

  localparam int DEC_W = 22;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    DS_OKAY = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

endpackage

// File: rtl/ahb_mtx_decoder_gen_if.sv
// ---------------------------------------------------------------------------
// ahb_mtx_decoder_gen_if
// Input-stage side of the matrix decoder.
//   master : the input stage (drives address phase, HREADYS; sees responses)
//   slave  : the decoder (sees address phase; drives muxed responses)
// Signals:
//   HREADYS, sel_dec, decode_addr_dec[21:0], trans_dec[1:0]  (input stage -> decoder)
//   active_dec, HREADYOUTS, HRESPS[1:0], HRDATAS, HRUSERS     (decoder -> input stage)
// ---------------------------------------------------------------------------
interface ahb_mtx_decoder_gen_if;
  import ahb_mtx_gen_pkg::*;

  logic             HREADYS;
  logic             sel_dec;
  logic [DEC_W-1:0] decode_addr_dec;
  logic [1:0]       trans_dec;
  logic             active_dec;
  logic             HREADYOUTS;
  logic [1:0]       HRESPS;
  logic [31:0]      HRDATAS;
  logic [31:0]      HRUSERS;

  modport master (
    output HREADYS, sel_dec, decode_addr_dec, trans_dec,
    input  active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS
  );

  modport slave (
    input  HREADYS, sel_dec, decode_addr_dec, trans_dec,
    output active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS
  );

endinterface

// File: rtl/ahb_mtx_decoder_gen_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_mtx_gen_default_slave
// Default slave for unmapped addresses. IDLE/BUSY get a zero-wait OKAY;
// NONSEQ/SEQ get a two-cycle ERROR (HREADYOUT low then high, HRESP=ERROR).
// Ports:
//   HCLK, HRESET   clock, async active-high reset
//   hsel_i         default slave selected by the decoder
//   htrans_i       HTRANS of the address phase
//   hready_i       input-stage HREADY
//   hreadyout_o    HREADYOUT of the default slave
//   hresp_o        HRESP of the default slave
//   err_start_o    pulses when an ERROR response is being started
// ---------------------------------------------------------------------------
module ahb_mtx_gen_default_slave
  import ahb_mtx_gen_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       hsel_i,
  input  logic [1:0] htrans_i,
  input  logic       hready_i,
  output logic       hreadyout_o,
  output logic [1:0] hresp_o,
  output logic       err_start_o
);

  ds_state_t state_q, state_d;
  logic      qualify;

  // A transfer only needs an ERROR when it is a real (NONSEQ/SEQ) transfer
  // accepted into the data phase.
  assign qualify = hsel_i & hready_i & htrans_i[1];

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= DS_OKAY;
    else        state_q <= state_d;
  end

  // Next state and response outputs. ERR1 always advances so the ERROR
  // response is exactly two cycles long.
  always_comb begin
    state_d     = state_q;
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    err_start_o = 1'b0;
    unique case (state_q)
      DS_OKAY: begin
        if (qualify) begin
          state_d     = DS_ERR1;
          err_start_o = 1'b1;
        end
      end
      DS_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = HRESP_ERROR;
        state_d     = DS_ERR2;
      end
      DS_ERR2: begin
        hresp_o = HRESP_ERROR;
        if (qualify) begin
          state_d     = DS_ERR1;
          err_start_o = 1'b1;
        end else begin
          state_d = DS_OKAY;
        end
      end
      default: state_d = DS_OKAY;
    endcase
  end

endmodule

// File: rtl/ahb_mtx_decoder_gen.sv
// ---------------------------------------------------------------------------
// ahb_mtx_decoder_gen
// Input-stage decoder for the AHB bus matrix with NUM_PORTS output stages.
// Decodes HADDR[31:10] against per-port 1 KB-granular regions, drives a
// one-hot HSEL, muxes data-phase responses, and uses an internal ERROR
// default slave for unmapped addresses, capturing the first such address.
// Optional macro: AHB_MTX_DEC_ERR_CNT_EN adds a saturating err_cnt output.
// Ports:
//   HCLK, HRESET      clock, async active-high reset
//   bus (slave)       input-stage address phase in, muxed responses out
//   active_dec_i      per-port active flag
//   readyout_dec_i    per-port HREADYOUT
//   resp_dec_i        per-port HRESP (2 bits each)
//   rdata_dec_i       per-port HRDATA (32 bits each)
//   ruser_dec_i       per-port HRUSER (32 bits each)
//   sel_dec_o         one-hot HSEL to output stages
//   err_valid/err_addr sticky capture of first unmapped access
//   err_clr           clears the capture (and counter)
//   err_cnt           ERROR entry count (macro only)
// ---------------------------------------------------------------------------
module ahb_mtx_decoder_gen
  import ahb_mtx_gen_pkg::*;
#(
  parameter int                       NUM_PORTS    = 4,
  parameter logic [DEC_W*NUM_PORTS-1:0] REGION_BASE  = {NUM_PORTS{22'h0}},
  parameter logic [DEC_W*NUM_PORTS-1:0] REGION_LIMIT = {NUM_PORTS{22'h3f}},
  parameter int                       PW           = $clog2(NUM_PORTS+1)
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  ahb_mtx_decoder_gen_if.slave    bus,
  input  logic [NUM_PORTS-1:0]    active_dec_i,
  input  logic [NUM_PORTS-1:0]    readyout_dec_i,
  input  logic [2*NUM_PORTS-1:0]  resp_dec_i,
  input  logic [32*NUM_PORTS-1:0] rdata_dec_i,
  input  logic [32*NUM_PORTS-1:0] ruser_dec_i,
  output logic [NUM_PORTS-1:0]    sel_dec_o,
  output logic                    err_valid,
  output logic [DEC_W-1:0]        err_addr,
`ifdef AHB_MTX_DEC_ERR_CNT_EN
  output logic [15:0]             err_cnt,
`endif
  input  logic                    err_clr
);

  localparam logic [PW-1:0] DFT_PORT = PW'(NUM_PORTS);

  logic [PW-1:0]    hit_port;
  logic [PW-1:0]    addr_port;
  logic [PW-1:0]    data_port_q;
  logic             sel_dft;
  logic             ds_readyout;
  logic [1:0]       ds_resp;
  logic             err_start;
  logic             err_valid_q, err_valid_d;
  logic [DEC_W-1:0] err_addr_q, err_addr_d;

  // Region match: scanning from the top down lets the lowest matching index
  // win on overlaps. IDLE keeps the previous data-phase port so HSEL does not
  // hop between ports on idle cycles.
  always_comb begin
    hit_port = DFT_PORT;
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      if ((REGION_BASE[DEC_W*i +: DEC_W] <= bus.decode_addr_dec) &&
          (bus.decode_addr_dec <= REGION_LIMIT[DEC_W*i +: DEC_W]))
        hit_port = PW'(i);
    end
    addr_port = (bus.trans_dec == HTRANS_IDLE) ? data_port_q : hit_port;
  end

  // One-hot HSEL and active flag for the address-phase port; the default
  // slave is always considered active.
  always_comb begin
    sel_dec_o      = '0;
    bus.active_dec = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_port == PW'(i)) begin
        sel_dec_o[i]   = bus.sel_dec;
        bus.active_dec = active_dec_i[i];
      end
    end
  end

  assign sel_dft = bus.sel_dec & (addr_port == DFT_PORT);

  // Data-phase port follows the input-stage HREADY, so it only advances when
  // the current data phase has completed.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)           data_port_q <= '0;
    else if (bus.HREADYS) data_port_q <= addr_port;
  end

  // Response mux back to the input stage; default slave returns zero data.
  always_comb begin
    bus.HREADYOUTS = ds_readyout;
    bus.HRESPS     = ds_resp;
    bus.HRDATAS    = '0;
    bus.HRUSERS    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (data_port_q == PW'(i)) begin
        bus.HREADYOUTS = readyout_dec_i[i];
        bus.HRESPS     = resp_dec_i[2*i +: 2];
        bus.HRDATAS    = rdata_dec_i[32*i +: 32];
        bus.HRUSERS    = ruser_dec_i[32*i +: 32];
      end
    end
  end

  ahb_mtx_gen_default_slave u_dft (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .hsel_i      (sel_dft),
    .htrans_i    (bus.trans_dec),
    .hready_i    (bus.HREADYS),
    .hreadyout_o (ds_readyout),
    .hresp_o     (ds_resp),
    .err_start_o (err_start)
  );

  // Sticky first-error capture; a clear drops any error arriving with it.
  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    if (err_clr) begin
      err_valid_d = 1'b0;
      err_addr_d  = '0;
    end else if (err_start && !err_valid_q) begin
      err_valid_d = 1'b1;
      err_addr_d  = bus.decode_addr_dec;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;

`ifdef AHB_MTX_DEC_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Counts every ERROR entry, saturating; clear wins over an increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr)                              err_cnt_d = '0;
    else if (err_start && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_ahb_mtx_decoder_gen.sv
// ---------------------------------------------------------------------------
// tb_ahb_mtx_decoder_gen
// Directed bench for the generic matrix decoder with four ports:
// port0 0x000-0x03F, port1 0x040-0x07F, port2 0x400-0x4FF, port3 0x800-0xFFF.
// HREADYS is looped back from HREADYOUTS, as a real input stage would do.
// ---------------------------------------------------------------------------
module tb_ahb_mtx_decoder_gen;
  import ahb_mtx_gen_pkg::*;

  localparam int NP = 4;

  logic                 HCLK = 1'b0;
  logic                 HRESET;
  logic [NP-1:0]        active_dec_i;
  logic [NP-1:0]        readyout_dec_i;
  logic [2*NP-1:0]      resp_dec_i;
  logic [32*NP-1:0]     rdata_dec_i;
  logic [32*NP-1:0]     ruser_dec_i;
  logic [NP-1:0]        sel_dec_o;
  logic                 err_valid;
  logic [21:0]          err_addr;
  logic                 err_clr;
`ifdef AHB_MTX_DEC_ERR_CNT_EN
  logic [15:0]          err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  ahb_mtx_decoder_gen_if bus ();

  assign bus.HREADYS = bus.HREADYOUTS;

  ahb_mtx_decoder_gen #(
    .NUM_PORTS    (NP),
    .REGION_BASE  ({22'h800, 22'h400, 22'h040, 22'h000}),
    .REGION_LIMIT ({22'hFFF, 22'h4FF, 22'h07F, 22'h03F})
  ) dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .bus            (bus.slave),
    .active_dec_i   (active_dec_i),
    .readyout_dec_i (readyout_dec_i),
    .resp_dec_i     (resp_dec_i),
    .rdata_dec_i    (rdata_dec_i),
    .ruser_dec_i    (ruser_dec_i),
    .sel_dec_o      (sel_dec_o),
    .err_valid      (err_valid),
    .err_addr       (err_addr),
`ifdef AHB_MTX_DEC_ERR_CNT_EN
    .err_cnt        (err_cnt),
`endif
    .err_clr        (err_clr)
  );

  always #5 HCLK = ~HCLK;

  // Drive the address phase and give combinational outputs time to settle.
  task automatic applyStimulus(input logic sel, input logic [1:0] trans,
                               input logic [21:0] addr, input logic clr);
    bus.sel_dec         = sel;
    bus.trans_dec       = trans;
    bus.decode_addr_dec = addr;
    err_clr             = clr;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    HRESET         = 1'b1;
    active_dec_i   = 4'b1101;
    readyout_dec_i = 4'b1111;
    resp_dec_i     = 8'h00;
    rdata_dec_i    = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    ruser_dec_i    = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
    applyStimulus(1'b1, HTRANS_IDLE, 22'h0, 1'b0);
    #2;

    // Reset state: data_port 0, IDLE holds port 0
    checkOutput("rst_readyout", 32'(bus.HREADYOUTS), 32'h1);
    checkOutput("rst_resp",     32'(bus.HRESPS),     32'h0);
    checkOutput("rst_rdata",    bus.HRDATAS,         32'hA000_0000);
    checkOutput("rst_errvalid", 32'(err_valid),      32'h0);
    checkOutput("rst_erraddr",  32'(err_addr),       32'h0);
    checkOutput("rst_sel",      32'(sel_dec_o),      32'h1);
`ifdef AHB_MTX_DEC_ERR_CNT_EN
    checkOutput("rst_errcnt",   32'(err_cnt),        32'h0);
`endif
    HRESET = 1'b0;
    nextCycle();

    // Decode to port1 (field 0x048); port1 is inactive
    applyStimulus(1'b1, HTRANS_NONSEQ, 22'h048, 1'b0);
    checkOutput("p1_sel",    32'(sel_dec_o),      32'h2);
    checkOutput("p1_active", 32'(bus.active_dec), 32'h0);
    nextCycle();

    // Idle with port3 address keeps port1 selected; data from port1
    applyStimulus(1'b1, HTRANS_IDLE, 22'hC00, 1'b0);
    checkOutput("idle_sel", 32'(sel_dec_o), 32'h2);
    checkOutput("p1_rdata", bus.HRDATAS,    32'hA000_0001);
    checkOutput("p1_ruser", bus.HRUSERS,    32'hB000_0001);
    nextCycle();

    // Unmapped access 0x2000_0000
    applyStimulus(1'b1, HTRANS_NONSEQ, 22'h080000, 1'b0);
    checkOutput("um_sel",    32'(sel_dec_o),      32'h0);
    checkOutput("um_active", 32'(bus.active_dec), 32'h1);
    nextCycle();
    applyStimulus(1'b1, HTRANS_IDLE, 22'h0, 1'b0);
    checkOutput("um_err1_ready", 32'(bus.HREADYOUTS), 32'h0);
    checkOutput("um_err1_resp",  32'(bus.HRESPS),     32'h1);
    checkOutput("um_rdata",      bus.HRDATAS,         32'h0);
    checkOutput("um_ruser",      bus.HRUSERS,         32'h0);
    checkOutput("um_errvalid",   32'(err_valid),      32'h1);
    checkOutput("um_erraddr",    32'(err_addr),       32'h080000);
    nextCycle();
    checkOutput("um_err2_ready", 32'(bus.HREADYOUTS), 32'h1);
    checkOutput("um_err2_resp",  32'(bus.HRESPS),     32'h1);
    checkOutput("um_idle_sel",   32'(sel_dec_o),      32'h0);
    nextCycle();
    checkOutput("um_okay_resp",  32'(bus.HRESPS),     32'h0);
`ifdef AHB_MTX_DEC_ERR_CNT_EN
    checkOutput("um_errcnt",     32'(err_cnt),        32'h1);
`endif

    // Clear capture
    applyStimulus(1'b0, HTRANS_IDLE, 22'h0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, HTRANS_IDLE, 22'h0, 1'b0);
    checkOutput("clr_errvalid", 32'(err_valid), 32'h0);
    checkOutput("clr_erraddr",  32'(err_addr),  32'h0);

    // Back-to-back unmapped: NONSEQ then SEQ held across ERR1
    applyStimulus(1'b1, HTRANS_NONSEQ, 22'h100000, 1'b0);
    nextCycle();
    applyStimulus(1'b1, HTRANS_SEQ, 22'h100001, 1'b0);
    checkOutput("b2b_err1a_ready", 32'(bus.HREADYOUTS), 32'h0);
    checkOutput("b2b_err1a_resp",  32'(bus.HRESPS),     32'h1);
    nextCycle();
    checkOutput("b2b_err2a_ready", 32'(bus.HREADYOUTS), 32'h1);
    checkOutput("b2b_err2a_resp",  32'(bus.HRESPS),     32'h1);
    nextCycle();
    applyStimulus(1'b1, HTRANS_IDLE, 22'h0, 1'b0);
    checkOutput("b2b_err1b_ready", 32'(bus.HREADYOUTS), 32'h0);
    checkOutput("b2b_err1b_resp",  32'(bus.HRESPS),     32'h1);
    checkOutput("b2b_erraddr",     32'(err_addr),       32'h100000);
    nextCycle();
    checkOutput("b2b_err2b_ready", 32'(bus.HREADYOUTS), 32'h1);
    checkOutput("b2b_err2b_resp",  32'(bus.HRESPS),     32'h1);
    nextCycle();
    checkOutput("b2b_okay_resp",   32'(bus.HRESPS),     32'h0);
`ifdef AHB_MTX_DEC_ERR_CNT_EN
    checkOutput("b2b_errcnt",      32'(err_cnt),        32'h2);
`endif

    // Wait states on port2 while next address targets port0
    applyStimulus(1'b1, HTRANS_NONSEQ, 22'h400, 1'b0);
    checkOutput("p2_sel", 32'(sel_dec_o), 32'h4);
    nextCycle();
    readyout_dec_i = 4'b1011;
    applyStimulus(1'b1, HTRANS_NONSEQ, 22'h010, 1'b0);
    for (int w = 0; w < 3; w++) begin
      checkOutput("ws_ready", 32'(bus.HREADYOUTS), 32'h0);
      checkOutput("ws_sel",   32'(sel_dec_o),      32'h1);
      checkOutput("ws_rdata", bus.HRDATAS,         32'hA000_0002);
      nextCycle();
    end
    readyout_dec_i = 4'b1111;
    #1;
    checkOutput("ws_done_ready", 32'(bus.HREADYOUTS), 32'h1);
    checkOutput("ws_done_rdata", bus.HRDATAS,         32'hA000_0002);
    nextCycle();
    applyStimulus(1'b1, HTRANS_IDLE, 22'hC00, 1'b0);
    checkOutput("p0_rdata", bus.HRDATAS,    32'hA000_0000);
    checkOutput("p0_sel",   32'(sel_dec_o), 32'h1);

    // Reset pulse during ERR1; later error must not overwrite capture
    applyStimulus(1'b1, HTRANS_NONSEQ, 22'h200000, 1'b0);
    nextCycle();
    applyStimulus(1'b0, HTRANS_IDLE, 22'h0, 1'b0);
    checkOutput("rm_err1_ready", 32'(bus.HREADYOUTS), 32'h0);
    checkOutput("rm_keepaddr",   32'(err_addr),       32'h100000);
    HRESET = 1'b1;
    #1;
    checkOutput("rm_ready",    32'(bus.HREADYOUTS), 32'h1);
    checkOutput("rm_resp",     32'(bus.HRESPS),     32'h0);
    checkOutput("rm_errvalid", 32'(err_valid),      32'h0);
    checkOutput("rm_rdata",    bus.HRDATAS,         32'hA000_0000);
    #1;
    HRESET = 1'b0;
    nextCycle();
    checkOutput("rm_post_ready", 32'(bus.HREADYOUTS), 32'h1);
    checkOutput("rm_post_resp",  32'(bus.HRESPS),     32'h0);
`ifdef AHB_MTX_DEC_ERR_CNT_EN
    checkOutput("rm_errcnt",     32'(err_cnt),        32'h0);
`endif

    // Clear coincident with a new error drops the capture
    applyStimulus(1'b1, HTRANS_NONSEQ, 22'h300000, 1'b1);
    nextCycle();
    applyStimulus(1'b0, HTRANS_IDLE, 22'h0, 1'b0);
    checkOutput("cc_err1_ready", 32'(bus.HREADYOUTS), 32'h0);
    checkOutput("cc_errvalid",   32'(err_valid),      32'h0);
    checkOutput("cc_erraddr",    32'(err_addr),       32'h0);
`ifdef AHB_MTX_DEC_ERR_CNT_EN
    checkOutput("cc_errcnt",     32'(err_cnt),        32'h0);
`endif
    nextCycle();
    nextCycle();
    checkOutput("cc_okay_resp",  32'(bus.HRESPS),     32'h0);
    checkOutput("cc_errvalid2",  32'(err_valid),      32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_mtx_decoder_gen.md
Name: ahb_mtx_decoder_gen

Overview:
Parametrised input-stage decoder for the AHB bus matrix. It generalises the per-slave-interface decoder to NUM_PORTS output stages with programmable 1 KB-granular address regions. It integrates a two-cycle ERROR default slave and captures the address of the first unmapped access. It sits between an input stage and its output stages. It drives one-hot HSEL per output port and muxes data-phase responses back to the input stage.

Parameters:
NUM_PORTS, 4, number of output stages (1..8)
REGION_BASE, {NUM_PORTS{22'h0}}, flattened per-port region base, as HADDR[31:10]; port i is at bits [22*i+21:22*i]
REGION_LIMIT, {NUM_PORTS{22'h3f}}, flattened per-port inclusive region limit, as HADDR[31:10]
PW, $clog2(NUM_PORTS+1), internal port-index width; value NUM_PORTS denotes the default slave

Ports:
HCLK  in  1  AHB clock
HRESET  in  1  asynchronous, active-high reset
HREADYS  in  1  input-stage HREADY (transfer done)
sel_dec  in  1  HSEL from input stage
decode_addr_dec  in  22  HADDR[31:10]
trans_dec  in  2  HTRANS
active_dec_i  in  NUM_PORTS  per-output-stage active flag
readyout_dec_i  in  NUM_PORTS  per-port HREADYOUT
resp_dec_i  in  2*NUM_PORTS  per-port HRESP
rdata_dec_i  in  32*NUM_PORTS  per-port HRDATA
ruser_dec_i  in  32*NUM_PORTS  per-port HRUSER
sel_dec_o  out  NUM_PORTS  one-hot HSEL to output stages
active_dec  out  1  combinational active for selected port
HREADYOUTS  out  1  muxed HREADYOUT
HRESPS  out  2  muxed HRESP (00 OKAY, 01 ERROR)
HRDATAS  out  32  muxed read data
HRUSERS  out  32  muxed user read data
err_valid  out  1  sticky: unmapped access captured
err_addr  out  22  HADDR[31:10] of first unmapped access
err_clr  in  1  clears err_valid/err_addr

Behaviour:
- One clock (HCLK). Reset is asynchronous and active-high (HRESET). All state is reset while HRESET=1.
- Address decode is combinational:
  - addr_port = lowest i with REGION_BASE[i] <= decode_addr_dec <= REGION_LIMIT[i]; otherwise NUM_PORTS (default slave).
  - Overlapping regions resolve to the lowest index.
  - Idle hold: if trans_dec==IDLE, addr_port = data_port. This prevents HSEL toggling between ports on idle cycles.
- sel_dec_o[addr_port] = sel_dec when addr_port < NUM_PORTS; all zero otherwise. sel_dft = sel_dec & (addr_port==NUM_PORTS).
- active_dec = active_dec_i[addr_port] for a real port, 1 for the default slave.
- data_port register:
  - Reset value 0.
  - Loads addr_port on any HCLK edge with HREADYS=1; holds otherwise.
  - Loading uses HREADYS, not HREADYOUTS.
- Data-phase mux, selected by data_port:
  - HREADYOUTS, HRESPS, HRDATAS, HRUSERS come from the selected port.
  - When the default slave is selected: HRDATAS=0, HRUSERS=0, HREADYOUTS and HRESPS come from the default slave.
- Default slave FSM, states DS_OKAY, DS_ERR1, DS_ERR2:
  - DS_OKAY: HREADYOUT=1, HRESP=00. Moves to DS_ERR1 when sel_dft & HREADYS & trans_dec[1] (NONSEQ/SEQ). IDLE/BUSY get a zero-wait OKAY.
  - DS_ERR1: HREADYOUT=0, HRESP=01. Unconditionally moves to DS_ERR2.
  - DS_ERR2: HREADYOUT=1, HRESP=01. Moves to DS_ERR1 if another qualifying transfer is presented, else DS_OKAY.
  - Reset state is DS_OKAY.
- Outputs at reset: HREADYOUTS = readyout_dec_i[0], HRESPS = resp_dec_i[1:0], err_valid=0, err_addr=0, sel_dec_o follows combinational decode.
- Error capture:
  - On the DS_OKAY/DS_ERR2 -> DS_ERR1 transition with err_valid=0: err_addr <= decode_addr_dec, err_valid <= 1.
  - Later errors do not overwrite a captured address.
  - err_clr has priority over a same-cycle capture; the new error is dropped.
- Reset mid-ERROR returns to DS_OKAY, data_port=0, with no partial response.

Optional Feature:
- Macro: AHB_MTX_DEC_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt[15:0], reset 0.
  - Increments on every entry to DS_ERR1 and saturates at 16'hFFFF.
  - err_clr zeroes it; clear wins over a same-cycle increment.
- Undefined: no err_cnt port and no counter logic.

Decomposition:
- Package ahb_mtx_gen_pkg holds:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ).
  - HRESP_OKAY/HRESP_ERROR.
  - DS state encoding.
  - the 22-bit decode-field width constant.
- One sub-module, ahb_mtx_gen_default_slave, contains the default-slave FSM with HSEL/HTRANS/HREADY in and HREADYOUT/HRESP/err_start out.
- Decode, data_port register, mux and error capture stay in the top.

Test Plan:
- Decode and data phase: NUM_PORTS=4, regions 0x000-0x03F, 0x040-0x07F, 0x400-0x4FF, 0x800-0xFFF. NONSEQ to HADDR 0x0001_2000 (field 0x048) -> sel_dec_o=0010; next cycle HRDATAS=rdata port1.
- Unmapped access: NONSEQ to 0x2000_0000 -> sel_dec_o=0000; data phase HREADYOUTS=0/HRESPS=01, then 1/01; HRDATAS=0; err_valid=1, err_addr=22'h080000.
- Back-to-back unmapped SEQ: two ERROR pairs (ERR1, ERR2, ERR1, ERR2); err_addr keeps the first address. With the macro defined, err_cnt=2.
- Wait states: port2 readyout low 3 cycles while the next address hits port0 -> data_port stays 2 until HREADYS=1; HSEL port0 asserted throughout.
- Idle hold: IDLE with address in port3 region after a port1 transfer -> sel_dec_o=0010, not 1000.
- Reset/clear ordering: HRESET pulse during DS_ERR1 -> next cycle HREADYOUTS follows port0, HRESPS=00, err_valid=0. err_clr coincident with a new error -> err_valid=0.
